// File: rtl/softmax_decision_if.sv
// softmax_decision_if: input-sample and result handshake bundle for the softmax decision stage
interface softmax_decision_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prob1;
    logic [31:0] prob2;
    logic        out_valid;
    logic        out_ready;
    logic        class_id;
    logic [31:0] confidence;
    logic        low_conf;
    logic        nan_flag;
    modport master (
        output in_valid, prob1, prob2, out_ready,
        input  in_ready, out_valid, class_id, confidence, low_conf, nan_flag
    );
    modport slave (
        input  in_valid, prob1, prob2, out_ready,
        output in_ready, out_valid, class_id, confidence, low_conf, nan_flag
    );
endinterface

// File: rtl/softmax_decision.sv
// softmax_decision: picks the winning class of two SPFP probabilities, flags low confidence / NaN, counts decisions
module softmax_decision #(
    parameter logic [31:0] CONF_THRESH = 32'h3F333333,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    softmax_decision_if.slave bus,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic is_nan(input logic [31:0] a);
        return a[30:23] == 8'hFF && a[22:0] != 23'd0;
    endfunction

    // sign-magnitude ordering; +0 and -0 compare equal, denormals by raw bits
    function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return !a[31];
        return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction

    logic             valid_q, cls_q, low_q, nan_q;
    logic [31:0]      conf_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             valid_d, cls_d, low_d, nan_d, accept, fire;
    logic [31:0]      conf_d;
    logic [CNT_W-1:0] cnt0_d, cnt1_d;

    assign bus.in_ready   = !valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign fire           = valid_q && bus.out_ready;
    assign bus.out_valid  = valid_q;
    assign bus.class_id   = cls_q;
    assign bus.confidence = conf_q;
    assign bus.low_conf   = low_q;
    assign bus.nan_flag   = nan_q;
    assign count0         = cnt0_q;
    assign count1         = cnt1_q;

    // decision on the incoming sample and next state of valid and counters
    always_comb begin
        nan_d   = is_nan(bus.prob1) || is_nan(bus.prob2);
        cls_d   = !nan_d && fgt(bus.prob2, bus.prob1);
        conf_d  = nan_d ? QNAN : (cls_d ? bus.prob2 : bus.prob1);
        low_d   = nan_d || fgt(CONF_THRESH, conf_d);
        valid_d = accept || (valid_q && !bus.out_ready);
        cnt0_d  = clr_counts ? '0 :
                  (fire && !nan_q && !cls_q && cnt0_q != '1) ? cnt0_q + CNT_W'(1) : cnt0_q;
        cnt1_d  = clr_counts ? '0 :
                  (fire && !nan_q && cls_q && cnt1_q != '1) ? cnt1_q + CNT_W'(1) : cnt1_q;
    end

    // result registers load only on accept so they hold under back-pressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            cls_q   <= 1'b0;
            conf_q  <= '0;
            low_q   <= 1'b0;
            nan_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            if (accept) begin
                cls_q  <= cls_d;
                conf_q <= conf_d;
                low_q  <= low_d;
                nan_q  <= nan_d;
            end
        end
    end
endmodule

// File: tb/tb_softmax_decision.sv
// tb_softmax_decision: directed vectors with hand-computed results for softmax_decision
module tb_softmax_decision;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_counts = 1'b0;
    logic [3:0] count0, count1;
    int         n_checks = 0;
    int         n_errors = 0;

    softmax_decision_if bus();

    softmax_decision #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .clr_counts(clr_counts), .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p1, input logic [31:0] p2);
        bus.in_valid = 1'b1;
        bus.prob1 = p1;
        bus.prob2 = p2;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic cls, input logic [31:0] conf,
                          input logic low, input logic nan);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".class"}, 32'(bus.class_id), 32'(cls));
        chk({tag, ".conf"}, bus.confidence, conf);
        chk({tag, ".low"}, 32'(bus.low_conf), 32'(low));
        chk({tag, ".nan"}, 32'(bus.nan_flag), 32'(nan));
    endtask

    task automatic counts(input string tag, input logic [3:0] c0, input logic [3:0] c1);
        chk({tag, ".count0"}, 32'(count0), 32'(c0));
        chk({tag, ".count1"}, 32'(count1), 32'(c1));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.prob1 = '0;
        bus.prob2 = '0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.class", 32'(bus.class_id), 32'd0);
        chk("rst.conf", bus.confidence, 32'd0);
        chk("rst.low", 32'(bus.low_conf), 32'd0);
        chk("rst.nan", 32'(bus.nan_flag), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        counts("rst", 4'd0, 4'd0);
        reset = 1'b0;
        step();
        send(32'h3F4CCCCD, 32'h3E4CCCCD);
        result("t1", 1'b0, 32'h3F4CCCCD, 1'b0, 1'b0);
        counts("t1.pre", 4'd0, 4'd0);
        step();
        chk("t1.drain", 32'(bus.out_valid), 32'd0);
        counts("t1.post", 4'd1, 4'd0);
        send(32'h3F000000, 32'h3F000000);
        result("tie", 1'b0, 32'h3F000000, 1'b1, 1'b0);
        step();
        send(32'h3E99999A, 32'h3F333333);
        result("thresh_eq", 1'b1, 32'h3F333333, 1'b0, 1'b0);
        step();
        counts("t2", 4'd2, 4'd1);
        send(32'h3F800000, 32'h7F800000);
        result("inf", 1'b1, 32'h7F800000, 1'b0, 1'b0);
        step();
        send(32'hBF800000, 32'h80000000);
        result("neg", 1'b1, 32'h80000000, 1'b1, 1'b0);
        step();
        send(32'h00000000, 32'h80000000);
        result("zeros", 1'b0, 32'h00000000, 1'b1, 1'b0);
        step();
        send(32'h00000001, 32'h00000002);
        result("denorm", 1'b1, 32'h00000002, 1'b1, 1'b0);
        step();
        counts("misc", 4'd3, 4'd4);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.prob1 = 32'h3E4CCCCD;
        bus.prob2 = 32'h3F4CCCCD;
        step();
        bus.prob1 = 32'h3F4CCCCD;
        bus.prob2 = 32'h3E4CCCCD;
        result("bp.0", 1'b1, 32'h3F4CCCCD, 1'b0, 1'b0);
        chk("bp.in_ready0", 32'(bus.in_ready), 32'd0);
        repeat (2) step();
        result("bp.2", 1'b1, 32'h3F4CCCCD, 1'b0, 1'b0);
        chk("bp.in_ready2", 32'(bus.in_ready), 32'd0);
        counts("bp.hold", 4'd3, 4'd4);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_up", 32'(bus.in_ready), 32'd1);
        step();
        result("bp.b", 1'b0, 32'h3F4CCCCD, 1'b0, 1'b0);
        counts("bp.b", 4'd3, 4'd5);
        bus.prob1 = 32'h3E99999A;
        bus.prob2 = 32'h3F333333;
        step();
        bus.in_valid = 1'b0;
        result("bp.c", 1'b1, 32'h3F333333, 1'b0, 1'b0);
        counts("bp.c", 4'd4, 4'd5);
        step();
        chk("bp.drain", 32'(bus.out_valid), 32'd0);
        counts("bp.end", 4'd4, 4'd6);
        send(32'h7FC00001, 32'h3F800000);
        result("nan", 1'b0, 32'h7FC00000, 1'b1, 1'b1);
        step();
        counts("nan", 4'd4, 4'd6);
        bus.in_valid = 1'b1;
        bus.prob1 = 32'h3E4CCCCD;
        bus.prob2 = 32'h3F4CCCCD;
        repeat (17) step();
        bus.in_valid = 1'b0;
        step();
        counts("sat", 4'd4, 4'hF);
        send(32'h3E4CCCCD, 32'h3F4CCCCD);
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0;
        chk("clr.valid", 32'(bus.out_valid), 32'd0);
        counts("clr", 4'd0, 4'd0);
        send(32'h3E4CCCCD, 32'h3F4CCCCD);
        step();
        counts("clr.after", 4'd0, 4'd1);
        bus.out_ready = 1'b0;
        send(32'h3F4CCCCD, 32'h3E4CCCCD);
        chk("arst.pre", 32'(bus.out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.out_valid), 32'd0);
        chk("arst.conf", bus.confidence, 32'd0);
        counts("arst", 4'd0, 4'd0);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        step();
        send(32'h3E4CCCCD, 32'h3F4CCCCD);
        result("arst.first", 1'b1, 32'h3F4CCCCD, 1'b0, 1'b0);
        step();
        counts("arst.first", 4'd0, 4'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
